master_write_burst: RTL and testbench

MASTER_WRITE_BURST -- requirements
Module: master_write_burst

---
 rtl/master_write_burst.sv | 131 +++++++++++++
 tb/tb_master_write_burst.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/master_write_burst.sv
// master_write_burst: turns one CPU write-burst request plus its beat stream
// into a single AXI INCR write burst and reports the B-channel response.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req_valid/ready    burst request handshake; req_addr, req_len (beats-1)
//   dat_valid/ready    per-beat handshake; dat_data, dat_strb
//   busy, done, resp   status: burst active, completion pulse, last response
//   AW*/W*/B*          AXI write address, data and response channels
module master_write_burst #(
  parameter logic [3:0] MASTER_ID = 4'b0001,
  parameter int         DATA_W    = 32,
  parameter int         LEN_W     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [31:0]         req_addr,
  input  logic [LEN_W-1:0]    req_len,
  input  logic                dat_valid,
  output logic                dat_ready,
  input  logic [DATA_W-1:0]   dat_data,
  input  logic [DATA_W/8-1:0] dat_strb,
  output logic                busy,
  output logic                done,
  output logic [1:0]          resp,
  output logic [3:0]          AWID,
  output logic [31:0]         AWADDR,
  output logic [LEN_W-1:0]    AWLEN,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [3:0]          BID,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY
);

  localparam int          STRB_W = DATA_W / 8;
  localparam int          SIZE   = $clog2(STRB_W);
  localparam logic [31:0] AMASK  = ~32'(STRB_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } state_t;

  state_t           state;
  logic [31:0]      addr_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic [1:0]       resp_q;
  logic             last;

  assign last = (cnt_q == len_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      addr_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      resp_q <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr & AMASK;
            len_q  <= req_len;
            state  <= ADDR;
          end
        end
        ADDR: begin
          if (AWREADY) begin
            cnt_q <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          if (dat_valid && WREADY) begin
            if (last) begin
              state <= RESP;
            end else begin
              cnt_q <= cnt_q + LEN_W'(1);
            end
          end
        end
        RESP: begin
          if (BVALID) begin
            // A response tagged for another master is reported as SLVERR.
            resp_q <= (BID == MASTER_ID) ? BRESP : 2'b10;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Held low while rst is asserted so the master reads as not ready.
  assign req_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);
  assign done      = (state == RESP) && BVALID;
  assign resp      = resp_q;

  assign AWVALID = (state == ADDR);
  assign AWID    = MASTER_ID;
  assign AWADDR  = addr_q;
  assign AWLEN   = len_q;
  assign AWSIZE  = 3'(SIZE);
  assign AWBURST = 2'b01;

  // W channel is a gated pass-through of the CPU beat stream.
  assign WVALID    = (state == DATA) && dat_valid;
  assign WDATA     = dat_data;
  assign WSTRB     = dat_strb;
  assign WLAST     = (state == DATA) && last;
  assign dat_ready = (state == DATA) && WREADY;

  assign BREADY = (state == RESP);

endmodule

// File: tb/tb_master_write_burst.sv
// tb_master_write_burst: randomized scoreboard bench for master_write_burst.
// Stimulus pushes expected AW/W/resp items; a negedge monitor pops and checks.
module tb_master_write_burst;

  localparam logic [3:0] MID = 4'b0001;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int SW = DW / 8;
  localparam int EXP_SIZE = (SW == 8) ? 3 : 2;

  typedef struct {
    logic [31:0]   addr;
    logic [LW-1:0] len;
  } aw_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
  } w_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } b_t;

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready;
  logic [31:0] req_addr;
  logic [LW-1:0] req_len;
  logic dat_valid, dat_ready;
  logic [DW-1:0] dat_data;
  logic [SW-1:0] dat_strb;
  logic busy, done;
  logic [1:0] resp;
  logic [3:0] AWID;
  logic [31:0] AWADDR;
  logic [LW-1:0] AWLEN;
  logic [2:0] AWSIZE;
  logic [1:0] AWBURST;
  logic AWVALID, AWREADY;
  logic [DW-1:0] WDATA;
  logic [SW-1:0] WSTRB;
  logic WLAST, WVALID, WREADY;
  logic [3:0] BID;
  logic [1:0] BRESP;
  logic BVALID, BREADY;

  master_write_burst #(
    .MASTER_ID(MID),
    .DATA_W(DW),
    .LEN_W(LW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .dat_valid(dat_valid), .dat_ready(dat_ready),
    .dat_data(dat_data), .dat_strb(dat_strb),
    .busy(busy), .done(done), .resp(resp),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  always #5 clk = ~clk;

  aw_t aw_q[$];
  w_t w_q[$];
  w_t feed_q[$];
  b_t b_q[$];
  logic [1:0] r_q[$];

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int stab_cnt = 0;
  int gap_cnt = 0;
  int wr_mode = 0;
  int aw_delay = 0;
  bit hold_req = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  int aw_out = 0;
  logic rst_prev = 1'b0;
  logic aw_pend = 1'b0;
  logic awv_prev = 1'b0;
  logic resp_pend = 1'b0;
  logic gap_armed = 1'b0;
  logic [1:0] resp_exp;
  int done_cyc = 0;
  aw_t aw_last;
  logic [3:0] id_last;
  aw_t ma;
  w_t mw;

  initial forever begin
    @(negedge clk);
    if (rst_prev) begin
      chk("rst_awvalid", AWVALID, 0);
      chk("rst_wvalid", WVALID, 0);
      chk("rst_bready", BREADY, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dat_ready", dat_ready, 0);
      chk("rst_req_ready", req_ready, !rst);
    end
    if (rst) begin
      aw_out = 0;
      aw_pend = 1'b0;
      resp_pend = 1'b0;
      gap_armed = 1'b0;
    end else begin
      if (resp_pend) begin
        chk("resp", resp, resp_exp);
        resp_pend = 1'b0;
      end
      if (aw_pend) begin
        chk("aw_hold_valid", AWVALID, 1);
        chk("aw_hold_addr", AWADDR, aw_last.addr);
        chk("aw_hold_len", AWLEN, aw_last.len);
        chk("aw_hold_id", AWID, id_last);
        stab_cnt++;
      end
      if (AWVALID && !awv_prev && gap_armed) begin
        chk("b2b_gap", cyc - done_cyc, 2);
        gap_cnt++;
        gap_armed = 1'b0;
      end
      if (AWVALID && AWREADY) begin
        chk("aw_expected", aw_q.size() > 0, 1);
        if (aw_q.size() > 0) begin
          ma = aw_q.pop_front();
          chk("awaddr", AWADDR, ma.addr);
          chk("awlen", AWLEN, ma.len);
          chk("awid", AWID, MID);
          chk("awsize", AWSIZE, EXP_SIZE);
          chk("awburst", AWBURST, 2'b01);
        end
        aw_out++;
      end
      aw_pend = AWVALID && !AWREADY;
      aw_last.addr = AWADDR;
      aw_last.len = AWLEN;
      id_last = AWID;
      if (!busy) chk("idle_no_wvalid", WVALID, 0);
      if (WVALID) begin
        chk("w_after_aw", aw_out > 0, 1);
        chk("w_from_cpu", dat_valid, 1);
        chk("dat_ready", dat_ready, WREADY);
      end
      if (WVALID && WREADY) begin
        chk("w_expected", w_q.size() > 0, 1);
        if (w_q.size() > 0) begin
          mw = w_q.pop_front();
          chk("wdata", WDATA, mw.data);
          chk("wstrb", WSTRB, mw.strb);
          chk("wlast", WLAST, mw.last);
        end
        if (WLAST) aw_out--;
      end
      if (done) begin
        chk("done_b_hs", BVALID && BREADY, 1);
        chk("done_expected", r_q.size() > 0, 1);
        if (r_q.size() > 0) begin
          resp_exp = r_q.pop_front();
          resp_pend = 1'b1;
        end
        done_cnt++;
        done_cyc = cyc;
        gap_armed = hold_req && req_valid;
      end
    end
    awv_prev = AWVALID && !rst;
    rst_prev = rst;
  end

  // ---------------- AXI slave ----------------
  int pend_b = 0;
  int aw_wait = 0;
  logic nx_awr, nx_wr, nx_bv;

  initial begin
    AWREADY = 1'b0;
    WREADY = 1'b0;
    BVALID = 1'b0;
    BID = 4'h0;
    BRESP = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend_b = 0;
        aw_wait = 0;
        nx_awr = 1'b0;
        nx_wr = 1'b0;
        nx_bv = 1'b0;
      end else begin
        if (WVALID && WREADY && WLAST) pend_b++;
        if (BVALID && BREADY) begin
          pend_b--;
          if (b_q.size() > 0) b_q.delete(0);
        end
        if (AWVALID && !AWREADY) aw_wait++;
        else aw_wait = 0;
        if (aw_delay > 0) nx_awr = AWVALID && (aw_wait >= aw_delay);
        else nx_awr = ($urandom_range(0, 3) != 0);
        if (wr_mode == 1) nx_wr = !WREADY;
        else nx_wr = ($urandom_range(0, 3) != 0);
        if (BVALID && !BREADY) nx_bv = 1'b1;
        else nx_bv = (pend_b > 0) && (b_q.size() > 0)
                     && ($urandom_range(0, 2) != 0);
      end
      @(posedge clk);
      #1;
      AWREADY = nx_awr;
      WREADY = nx_wr;
      BVALID = nx_bv;
      if (b_q.size() > 0) begin
        BID = b_q[0].id;
        BRESP = b_q[0].resp;
      end else begin
        BID = 4'($urandom);
        BRESP = 2'($urandom);
      end
    end
  end

  // ---------------- CPU side + reference model ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_burst(input logic [31:0] addr, input int len,
                             input logic [3:0] bid, input logic [1:0] br,
                             input bit fixed);
    aw_t a;
    w_t w;
    b_t b;
    a.addr = (addr / SW) * SW;
    a.len = LW'(len);
    aw_q.push_back(a);
    for (int i = 0; i <= len; i++) begin
      w.data = fixed ? DW'(32'hDEADBEEF) : DW'($urandom);
      w.strb = fixed ? '1 : SW'($urandom);
      w.last = (i == len);
      w_q.push_back(w);
      feed_q.push_back(w);
    end
    b.id = bid;
    b.resp = br;
    b_q.push_back(b);
    r_q.push_back((bid == MID) ? br : 2'b10);
  endtask

  task automatic send_req(input logic [31:0] addr, input int len);
    bit acc;
    req_valid = 1'b1;
    req_addr = addr;
    req_len = LW'(len);
    acc = 1'b0;
    for (int t = 0; t < 300 && !acc; t++) begin
      @(negedge clk);
      acc = req_ready;
      step();
    end
    chk("req_accept", acc, 1);
    if (!hold_req) begin
      req_valid = 1'b0;
      req_addr = $urandom;
    end
  endtask

  task automatic feed(input int n);
    int got;
    int t;
    bit hs;
    w_t w;
    got = 0;
    t = 0;
    while (got < n && t < 600) begin
      if (feed_q.size() > 0) w = feed_q[0];
      dat_valid = ($urandom_range(0, 3) != 0);
      dat_data = dat_valid ? w.data : DW'($urandom);
      dat_strb = dat_valid ? w.strb : SW'($urandom);
      @(negedge clk);
      hs = dat_valid && dat_ready;
      step();
      if (hs) begin
        feed_q.delete(0);
        got++;
      end
      t++;
    end
    dat_valid = 1'b0;
    chk("feed_beats", got, n);
  endtask

  task automatic burst(input logic [31:0] addr, input int len,
                       input logic [3:0] bid, input logic [1:0] br,
                       input bit fixed);
    model_burst(addr, len, bid, br, fixed);
    send_req(addr, len);
    feed(len + 1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((r_q.size() + w_q.size() + aw_q.size()) > 0 && t < 2000) begin
      step();
      t++;
    end
    chk("drain", r_q.size() + w_q.size() + aw_q.size(), 0);
    step();
    step();
  endtask

  function automatic logic [3:0] rnd_bid();
    if ($urandom_range(0, 4) == 0) return MID ^ 4'($urandom_range(1, 15));
    return MID;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int d0;
  int s0;
  int g0;
  logic [31:0] ra;

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    req_len = '0;
    dat_valid = 1'b0;
    dat_data = '0;
    dat_strb = '0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", req_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_resp", resp, 0);
    chk("reset_awvalid", AWVALID, 0);
    chk("reset_wvalid", WVALID, 0);
    chk("reset_bready", BREADY, 0);
    chk("reset_awaddr", AWADDR, 0);
    chk("reset_awlen", AWLEN, 0);
    step();

    // single beat, fixed pattern
    d0 = done_cnt;
    burst(32'h1000, 0, MID, 2'b00, 1'b1);
    wait_idle();
    chk("single_done", done_cnt - d0, 1);
    chk("single_resp", resp, 2'b00);

    // 4 beats with WREADY toggling and CPU data gaps
    wr_mode = 1;
    burst($urandom, 3, MID, 2'($urandom), 1'b0);
    wait_idle();
    wr_mode = 0;

    // AWREADY held off for 5 cycles
    aw_delay = 5;
    s0 = stab_cnt;
    burst($urandom, 2, MID, 2'b00, 1'b0);
    wait_idle();
    aw_delay = 0;
    chk("aw_hold_cycles", stab_cnt - s0 >= 5, 1);

    // foreign BID and error response
    burst($urandom, 1, 4'b0010, 2'b00, 1'b0);
    wait_idle();
    chk("bad_bid_resp", resp, 2'b10);
    burst($urandom, 2, MID, 2'b11, 1'b0);
    wait_idle();
    chk("bresp11_resp", resp, 2'b11);

    // reset during beat 2 of a 16-beat burst
    d0 = done_cnt;
    ra = $urandom;
    model_burst(ra, 15, MID, 2'b01, 1'b0);
    send_req(ra, 15);
    feed(1);
    dat_valid = 1'b1;
    dat_data = feed_q[0].data;
    rst = 1'b1;
    aw_q.delete();
    w_q.delete();
    feed_q.delete();
    b_q.delete();
    r_q.delete();
    step();
    step();
    rst = 1'b0;
    dat_valid = 1'b0;
    repeat (4) step();
    chk("abort_no_done", done_cnt - d0, 0);
    burst($urandom, 15, MID, 2'b01, 1'b0);
    wait_idle();
    chk("after_abort_done", done_cnt - d0, 1);

    // random bursts
    for (int i = 0; i < 20; i++) begin
      burst($urandom, $urandom_range(0, 15), rnd_bid(), 2'($urandom), 1'b0);
      wait_idle();
    end

    // request held high: back-to-back bursts
    hold_req = 1'b1;
    g0 = gap_cnt;
    for (int i = 0; i < 4; i++) begin
      burst($urandom, $urandom_range(0, 5), rnd_bid(), 2'($urandom), 1'b0);
    end
    hold_req = 1'b0;
    req_valid = 1'b0;
    wait_idle();
    chk("b2b_gap_count", gap_cnt - g0, 3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
